// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and the baud divisor helper.
package uart_pkg;

    typedef enum logic [2:0] {HUNT, IDLE, START, DATA, STOP} uart_rx_state_e;

    // Clock cycles per bit, rounded to nearest.
    function automatic int unsigned uart_baud_div(input int unsigned clk_hz,
                                                  input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer with a selectable reset value.
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with a one-byte valid/ready holding register,
// framing-error and overrun pulses.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BAUD_RATE   = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned DIV  = uart_baud_div(CLK_FREQ_HZ, BAUD_RATE);
    localparam int unsigned HALF = DIV / 2;
    localparam int          CW   = $clog2(DIV);

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);

    // Too few cycles per bit leaves no room for a mid-bit sample.
    if (DIV < 16) begin : g_div_check
        $fatal(1, "uart_rx_core: baud divisor below 16");
    end

    logic rx_s;

    uart_sync #(.RESET_VAL(1'b1)) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    uart_rx_state_e state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [7:0]     shift_q, shift_d;
    logic [7:0]     m_data_q;
    logic           m_valid_q;
    logic           frame_err_q;
    logic           overrun_q;
    logic           byte_done;
    logic           stop_bad;

    // Receiver state, bit timer and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    // Frame sequencing: start-bit qualification, mid-bit data and stop samples.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        stop_bad  = 1'b0;
        case (state_q)
            HUNT: begin
                // Wait for an idle line so we never lock onto a frame mid-way.
                if (rx_s) state_d = IDLE;
            end
            IDLE: begin
                if (!rx_s) begin
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_MID) begin
                    if (!rx_s) begin
                        cnt_d     = '0;
                        bit_idx_d = '0;
                        state_d   = DATA;
                    end else begin
                        state_d = IDLE;  // too short to be a start bit
                    end
                end
            end
            DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        byte_done = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = HUNT;
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    // Holding register: a same-cycle pop makes room for the new byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data_q    <= 8'h00;
            m_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (byte_done && (!m_valid_q || m_ready)) begin
                m_data_q  <= shift_q;
                m_valid_q <= 1'b1;
            end else if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
            end
            frame_err_q <= stop_bad;
            overrun_q   <= byte_done && m_valid_q && !m_ready;
        end
    end

    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core at DIV=16, HALF=8.
module tb_uart_rx_core;

    localparam int unsigned CLK_HZ = 1_600_000;
    localparam int unsigned BAUD   = 100_000;
    localparam int          DIV    = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       frame_err;
    logic       overrun;

    always #5 clk = ~clk;

    uart_rx_core #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int valid_cycles = 0;
    int fe_pulses    = 0;
    int ov_pulses    = 0;

    // Observe outputs mid-cycle: accepted bytes and pulse counts.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid) valid_cycles++;
            if (m_valid && m_ready) obs_q.push_back(m_data);
            if (frame_err) fe_pulses++;
            if (overrun) ov_pulses++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one 8N1 frame, LSB first; stop bit level is selectable.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(DIV);
        end
        rx = stop;
        tick(DIV);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rx = 1'b1; m_ready = 1'b0;
        #23;
        checks++; if (m_data !== 8'h00) begin failures++; $display("FAIL reset_m_data: got %h want 00", m_data); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(5);
    endtask

    task automatic test_basic;
        int n0, v0, f0, o0;
        n0 = exp_q.size(); v0 = valid_cycles; f0 = fe_pulses; o0 = ov_pulses;
        m_ready = 1'b1;
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        tick(10);
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL basic_count: got %0d bytes want %0d", obs_q.size(), exp_q.size()); end
        for (int i = n0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL basic_data: got %h want %h", obs_q[i], exp_q[i]); end
        end
        checks++; if (valid_cycles - v0 != 1) begin failures++; $display("FAIL basic_valid_width: got %0d cycles want 1", valid_cycles - v0); end
        checks++; if (fe_pulses != f0) begin failures++; $display("FAIL basic_frame_err: got %0d pulses want 0", fe_pulses - f0); end
        checks++; if (ov_pulses != o0) begin failures++; $display("FAIL basic_overrun: got %0d pulses want 0", ov_pulses - o0); end
    endtask

    task automatic test_glitch;
        int n0, v0;
        n0 = exp_q.size(); v0 = valid_cycles;
        m_ready = 1'b1;
        rx = 1'b0; tick(3);
        rx = 1'b1; tick(30);
        checks++; if (valid_cycles != v0) begin failures++; $display("FAIL glitch_no_valid: got %0d cycles want 0", valid_cycles - v0); end
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        tick(10);
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL glitch_count: got %0d bytes want %0d", obs_q.size(), exp_q.size()); end
        for (int i = n0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL glitch_data: got %h want %h", obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_frame_err;
        int n0, v0, f0, o0;
        n0 = exp_q.size(); v0 = valid_cycles; f0 = fe_pulses; o0 = ov_pulses;
        m_ready = 1'b1;
        send_frame(8'hA3, 1'b0);
        rx = 1'b0; tick(50);
        checks++; if (fe_pulses - f0 != 1) begin failures++; $display("FAIL ferr_pulse: got %0d pulses want 1", fe_pulses - f0); end
        checks++; if (valid_cycles != v0) begin failures++; $display("FAIL ferr_no_valid: got %0d cycles want 0", valid_cycles - v0); end
        rx = 1'b1; tick(20);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        tick(10);
        checks++; if (fe_pulses - f0 != 1) begin failures++; $display("FAIL ferr_total: got %0d pulses want 1", fe_pulses - f0); end
        checks++; if (ov_pulses != o0) begin failures++; $display("FAIL ferr_overrun: got %0d pulses want 0", ov_pulses - o0); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL ferr_count: got %0d bytes want %0d", obs_q.size(), exp_q.size()); end
        for (int i = n0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL ferr_data: got %h want %h", obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_overrun;
        int n0, f0, o0;
        n0 = exp_q.size(); f0 = fe_pulses; o0 = ov_pulses;
        m_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(10);
        checks++; if (ov_pulses - o0 != 1) begin failures++; $display("FAIL ovr_pulse: got %0d pulses want 1", ov_pulses - o0); end
        checks++; if (fe_pulses != f0) begin failures++; $display("FAIL ovr_frame_err: got %0d pulses want 0", fe_pulses - f0); end
        checks++; if (m_data !== 8'h11) begin failures++; $display("FAIL ovr_hold_data: got %h want 11", m_data); end
        checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL ovr_hold_valid: got %b want 1", m_valid); end
        m_ready = 1'b1;
        tick(3);
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL ovr_drain_valid: got %b want 0", m_valid); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL ovr_count: got %0d bytes want %0d", obs_q.size(), exp_q.size()); end
        for (int i = n0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL ovr_data: got %h want %h", obs_q[i], exp_q[i]); end
        end
    endtask

    // Pop the held byte in exactly the cycle the next byte completes.
    task automatic test_back_to_back;
        int n0, o0;
        n0 = exp_q.size(); o0 = ov_pulses;
        m_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        tick(4);
        exp_q.push_back(8'h22);
        fork
            send_frame(8'h22, 1'b1);
            begin
                tick(154);
                checks++; if (m_data !== 8'h11 || m_valid !== 1'b1) begin failures++; $display("FAIL b2b_pre: got %h/%b want 11/1", m_data, m_valid); end
                m_ready = 1'b1;
                tick(1);
                m_ready = 1'b0;
                checks++; if (m_data !== 8'h22) begin failures++; $display("FAIL b2b_load_data: got %h want 22", m_data); end
                checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL b2b_keep_valid: got %b want 1", m_valid); end
                checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun_now: got %b want 0", overrun); end
            end
        join
        m_ready = 1'b1;
        tick(4);
        checks++; if (ov_pulses != o0) begin failures++; $display("FAIL b2b_overrun: got %0d pulses want 0", ov_pulses - o0); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_count: got %0d bytes want %0d", obs_q.size(), exp_q.size()); end
        for (int i = n0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_data: got %h want %h", obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_midframe;
        int n0, v0;
        n0 = exp_q.size(); v0 = valid_cycles;
        m_ready = 1'b1;
        rx = 1'b0;          // start bit plus data bits 0..3 of 0xF0 are all low
        tick(70);           // inside data bit 3
        rst_n = 1'b0;
        rx = 1'b1;
        #2;
        checks++; if (m_data !== 8'h00) begin failures++; $display("FAIL mrst_m_data: got %h want 00", m_data); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL mrst_m_valid: got %b want 0", m_valid); end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL mrst_pulses: got %b/%b want 0/0", frame_err, overrun); end
        tick(3);
        rst_n = 1'b1;
        tick(30);
        checks++; if (valid_cycles != v0) begin failures++; $display("FAIL mrst_no_byte: got %0d cycles want 0", valid_cycles - v0); end
        exp_q.push_back(8'hF0);
        send_frame(8'hF0, 1'b1);
        tick(10);
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL mrst_count: got %0d bytes want %0d", obs_q.size(), exp_q.size()); end
        for (int i = n0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL mrst_data: got %h want %h", obs_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_glitch;
        test_frame_err;
        test_overrun;
        test_back_to_back;
        test_reset_midframe;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
